// File: rtl/id_ex_operand_stage_pkg.sv
// Shared definitions for the ID->EX operand stage.
// Forwarding select codes, FSM states and default widths.
package id_ex_operand_stage_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;
    localparam int CTRL_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;

    localparam logic [1:0] LM_RF  = 2'b00;
    localparam logic [1:0] LM_EXE = 2'b01;
    localparam logic [1:0] LM_MEM = 2'b10;
    localparam logic [1:0] LM_WB  = 2'b11;

    typedef enum logic {
        RUN       = 1'b0,
        LU_BUBBLE = 1'b1
    } state_t;

    // An operand depends on the EX result only if it is actually read.
    function automatic logic exe_fwd(
        input logic       use_op,
        input logic [1:0] lm
    );
        return use_op & (lm == LM_EXE);
    endfunction

endpackage

// File: rtl/id_ex_operand_stage_operand_fwd_mux.sv
// Four-way operand forwarding mux.
// Select codes follow the comparator encoding in the package.
module operand_fwd_mux
    import id_ex_operand_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
)(
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] rf_data,
    input  logic [DATA_W-1:0] exe_data,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = rf_data;
        unique case (sel)
            LM_RF:   data = rf_data;
            LM_EXE:  data = exe_data;
            LM_MEM:  data = mem_data;
            LM_WB:   data = wb_data;
            default: data = rf_data;
        endcase
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID->EX pipeline register with operand forwarding,
// load-use bubble insertion and a saturating bubble counter.
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic              id_useA,
    input  logic              id_useB,
    input  logic [ADDR_W-1:0] id_dest,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DATA_W-1:0] rf_dataA,
    input  logic [DATA_W-1:0] rf_dataB,
    input  logic [1:0]        lmA,
    input  logic [1:0]        lmB,
    input  logic [DATA_W-1:0] exe_result,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [DATA_W-1:0] wb_result,
    input  logic              exe_is_load,
    input  logic              flush,
    input  logic              ex_stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_opA,
    output logic [DATA_W-1:0] ex_opB,
    output logic [ADDR_W-1:0] ex_dest,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              stall_id,
    output logic [CNT_W-1:0]  stall_count
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] op_a;
        logic [DATA_W-1:0] op_b;
        logic [ADDR_W-1:0] dest;
        logic [CTRL_W-1:0] ctrl;
    } id_ex_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state;
    state_t            state_next;
    id_ex_t            ex_q;
    id_ex_t            ex_d;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic              hz;
    logic              do_hold;
    logic              do_flush;
    logic              do_bubble;
    logic              do_capture;

    operand_fwd_mux #(.DATA_W(DATA_W)) u_mux_a (
        .sel      (lmA),
        .rf_data  (rf_dataA),
        .exe_data (exe_result),
        .mem_data (mem_result),
        .wb_data  (wb_result),
        .data     (fwd_a)
    );

    operand_fwd_mux #(.DATA_W(DATA_W)) u_mux_b (
        .sel      (lmB),
        .rf_data  (rf_dataB),
        .exe_data (exe_result),
        .mem_data (mem_result),
        .wb_data  (wb_result),
        .data     (fwd_b)
    );

    // In LU_BUBBLE the load has moved to MEM, so no second bubble.
    assign hz = id_valid
              & exe_is_load
              & (state == RUN)
              & (exe_fwd(id_useA, lmA) | exe_fwd(id_useB, lmB));

    assign do_hold    = ex_stall;
    assign do_flush   = ~ex_stall & flush;
    assign do_bubble  = ~ex_stall & ~flush & hz;
    assign do_capture = ~(ex_stall | flush | hz);

    assign stall_id = do_hold | do_bubble;

    always_comb begin
        state_next = state;
        ex_d       = ex_q;
        unique case (1'b1)
            do_hold: begin
                state_next = state;
            end
            do_flush: begin
                ex_d.valid = 1'b0;
                state_next = RUN;
            end
            do_bubble: begin
                ex_d.valid = 1'b0;
                state_next = LU_BUBBLE;
            end
            do_capture: begin
                ex_d.valid = id_valid;
                ex_d.op_a  = fwd_a;
                ex_d.op_b  = fwd_b;
                ex_d.dest  = id_dest;
                ex_d.ctrl  = id_ctrl;
                state_next = RUN;
            end
            default: begin
                state_next = state;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            ex_q  <= '0;
        end else begin
            state <= state_next;
            ex_q  <= ex_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (do_bubble && stall_count != CNT_MAX) begin
            stall_count <= stall_count + CNT_ONE;
        end
    end

    assign ex_valid = ex_q.valid;
    assign ex_opA   = ex_q.op_a;
    assign ex_opB   = ex_q.op_b;
    assign ex_dest  = ex_q.dest;
    assign ex_ctrl  = ex_q.ctrl;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Testbench for id_ex_operand_stage: directed table, corner sequences,
// and randomized traffic against a cycle-level reference model.
module tb_id_ex_operand_stage;

    typedef struct {
        bit          rst;
        bit          vld;
        bit          ua;
        bit          ub;
        bit          ld;
        bit          fl;
        bit          st;
        logic [1:0]  lma;
        logic [1:0]  lmb;
        logic [2:0]  dest;
        logic [7:0]  ctrl;
        logic [15:0] rfa;
        logic [15:0] rfb;
        logic [15:0] exe;
        logic [15:0] mem;
        logic [15:0] wb;
        bit          e_stall;
        bit          e_valid;
        bit          e_ops;
        logic [15:0] e_opa;
        logic [15:0] e_opb;
        logic [2:0]  e_dest;
        logic [7:0]  e_ctrl;
        int          e_cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic        id_useA;
    logic        id_useB;
    logic [2:0]  id_dest;
    logic [7:0]  id_ctrl;
    logic [15:0] rf_dataA;
    logic [15:0] rf_dataB;
    logic [1:0]  lmA;
    logic [1:0]  lmB;
    logic [15:0] exe_result;
    logic [15:0] mem_result;
    logic [15:0] wb_result;
    logic        exe_is_load;
    logic        flush;
    logic        ex_stall;
    logic        ex_valid;
    logic [15:0] ex_opA;
    logic [15:0] ex_opB;
    logic [2:0]  ex_dest;
    logic [7:0]  ex_ctrl;
    logic        stall_id;
    logic [15:0] stall_count;

    logic        s_valid;
    logic [15:0] s_opA;
    logic [15:0] s_opB;
    logic [2:0]  s_dest;
    logic [7:0]  s_ctrl;
    logic        s_stall_id;
    logic [2:0]  s_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_useA(id_useA), .id_useB(id_useB),
        .id_dest(id_dest), .id_ctrl(id_ctrl),
        .rf_dataA(rf_dataA), .rf_dataB(rf_dataB),
        .lmA(lmA), .lmB(lmB),
        .exe_result(exe_result), .mem_result(mem_result),
        .wb_result(wb_result), .exe_is_load(exe_is_load),
        .flush(flush), .ex_stall(ex_stall),
        .ex_valid(ex_valid), .ex_opA(ex_opA), .ex_opB(ex_opB),
        .ex_dest(ex_dest), .ex_ctrl(ex_ctrl),
        .stall_id(stall_id), .stall_count(stall_count)
    );

    // Narrow-counter copy so saturation is reachable in a short run.
    id_ex_operand_stage #(.CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_useA(id_useA), .id_useB(id_useB),
        .id_dest(id_dest), .id_ctrl(id_ctrl),
        .rf_dataA(rf_dataA), .rf_dataB(rf_dataB),
        .lmA(lmA), .lmB(lmB),
        .exe_result(exe_result), .mem_result(mem_result),
        .wb_result(wb_result), .exe_is_load(exe_is_load),
        .flush(flush), .ex_stall(ex_stall),
        .ex_valid(s_valid), .ex_opA(s_opA), .ex_opB(s_opB),
        .ex_dest(s_dest), .ex_ctrl(s_ctrl),
        .stall_id(s_stall_id), .stall_count(s_count)
    );

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int sat7(input int n);
        return (n > 7) ? 7 : n;
    endfunction

    function automatic logic [15:0] pick(input logic [1:0] lm,
        input logic [15:0] rf, input logic [15:0] e,
        input logic [15:0] m, input logic [15:0] w);
        case (lm)
            2'd0:    return rf;
            2'd1:    return e;
            2'd2:    return m;
            default: return w;
        endcase
    endfunction

    task automatic drive(input vec_t v);
        reset       = v.rst;
        id_valid    = v.vld;
        id_useA     = v.ua;
        id_useB     = v.ub;
        exe_is_load = v.ld;
        flush       = v.fl;
        ex_stall    = v.st;
        lmA         = v.lma;
        lmB         = v.lmb;
        id_dest     = v.dest;
        id_ctrl     = v.ctrl;
        rf_dataA    = v.rfa;
        rf_dataB    = v.rfb;
        exe_result  = v.exe;
        mem_result  = v.mem;
        wb_result   = v.wb;
    endtask

    task automatic apply(input vec_t v, input string tag);
        drive(v);
        #1;
        chk({tag, " stall_id"}, 32'(stall_id), 32'(v.e_stall));
        chk({tag, " sat stall_id"}, 32'(s_stall_id), 32'(v.e_stall));
        @(posedge clk);
        #1;
        chk({tag, " ex_valid"}, 32'(ex_valid), 32'(v.e_valid));
        chk({tag, " stall_count"}, 32'(stall_count), 32'(v.e_cnt));
        chk({tag, " sat count"}, 32'(s_count), 32'(sat7(v.e_cnt)));
        if (v.e_ops) begin
            chk({tag, " ex_opA"}, 32'(ex_opA), 32'(v.e_opa));
            chk({tag, " ex_opB"}, 32'(ex_opB), 32'(v.e_opb));
            chk({tag, " ex_dest"}, 32'(ex_dest), 32'(v.e_dest));
            chk({tag, " ex_ctrl"}, 32'(ex_ctrl), 32'(v.e_ctrl));
        end
    endtask

    vec_t tbl[10];
    vec_t z;
    vec_t v;

    // Reference model state
    bit          m_valid;
    bit          m_bubble;
    logic [15:0] m_opa;
    logic [15:0] m_opb;
    logic [2:0]  m_dest;
    logic [7:0]  m_ctrl;
    int          m_cnt;

    initial begin
        z = '{default: '0};
        for (int i = 0; i < 10; i++) tbl[i] = z;

        // reset state
        tbl[0].rst = 1; tbl[0].e_ops = 1;
        // idle
        tbl[1].e_ops = 0;
        // MEM and WB forwarding
        tbl[2].vld = 1; tbl[2].ua = 1; tbl[2].ub = 1;
        tbl[2].lma = 2; tbl[2].lmb = 3;
        tbl[2].mem = 16'h1234; tbl[2].wb = 16'hBEEF;
        tbl[2].dest = 5; tbl[2].ctrl = 8'hA5;
        tbl[2].e_valid = 1; tbl[2].e_ops = 1;
        tbl[2].e_opa = 16'h1234; tbl[2].e_opb = 16'hBEEF;
        tbl[2].e_dest = 5; tbl[2].e_ctrl = 8'hA5;
        // load-use hazard on A
        tbl[3].vld = 1; tbl[3].ua = 1; tbl[3].lma = 1;
        tbl[3].ld = 1; tbl[3].exe = 16'h7777;
        tbl[3].rfb = 16'h0B0B;
        tbl[3].e_stall = 1; tbl[3].e_cnt = 1;
        // bubble cycle, load now in MEM
        tbl[4].vld = 1; tbl[4].ua = 1; tbl[4].lma = 2;
        tbl[4].mem = 16'h00A5; tbl[4].rfb = 16'h0B0B;
        tbl[4].dest = 2; tbl[4].ctrl = 8'h42;
        tbl[4].e_valid = 1; tbl[4].e_ops = 1;
        tbl[4].e_opa = 16'h00A5; tbl[4].e_opb = 16'h0B0B;
        tbl[4].e_dest = 2; tbl[4].e_ctrl = 8'h42; tbl[4].e_cnt = 1;
        // unused operand B selects EXE: no hazard, mux still drives
        tbl[5].vld = 1; tbl[5].ua = 1; tbl[5].lma = 0;
        tbl[5].rfa = 16'h1111; tbl[5].lmb = 1;
        tbl[5].exe = 16'h2222; tbl[5].ld = 1;
        tbl[5].dest = 7; tbl[5].ctrl = 8'h0F;
        tbl[5].e_valid = 1; tbl[5].e_ops = 1;
        tbl[5].e_opa = 16'h1111; tbl[5].e_opb = 16'h2222;
        tbl[5].e_dest = 7; tbl[5].e_ctrl = 8'h0F; tbl[5].e_cnt = 1;
        // flush wins over hazard
        tbl[6].vld = 1; tbl[6].ua = 1; tbl[6].lma = 1;
        tbl[6].ld = 1; tbl[6].fl = 1; tbl[6].exe = 16'h3333;
        tbl[6].e_cnt = 1;
        // hazard right after flush
        tbl[7] = tbl[6]; tbl[7].fl = 0;
        tbl[7].ub = 1; tbl[7].lmb = 3; tbl[7].wb = 16'h4444;
        tbl[7].e_stall = 1; tbl[7].e_cnt = 2;
        // same inputs in bubble: hazard suppressed
        tbl[8] = tbl[7]; tbl[8].dest = 3; tbl[8].ctrl = 8'h99;
        tbl[8].e_stall = 0; tbl[8].e_valid = 1; tbl[8].e_ops = 1;
        tbl[8].e_opa = 16'h3333; tbl[8].e_opb = 16'h4444;
        tbl[8].e_dest = 3; tbl[8].e_ctrl = 8'h99;
        // invalid instruction never hazards
        tbl[9].ua = 1; tbl[9].lma = 1; tbl[9].ld = 1;
        tbl[9].e_cnt = 2;

        for (int i = 0; i < 10; i++)
            apply(tbl[i], $sformatf("row%0d", i));

        // ex_stall held 3 cycles with a hazard pending
        v = z; v.vld = 1; v.ua = 1; v.ub = 1;
        v.rfa = 16'hABCD; v.rfb = 16'hDCBA;
        v.dest = 6; v.ctrl = 8'h3C;
        v.e_valid = 1; v.e_ops = 1;
        v.e_opa = 16'hABCD; v.e_opb = 16'hDCBA;
        v.e_dest = 6; v.e_ctrl = 8'h3C; v.e_cnt = 2;
        apply(v, "stall_pre");
        v.lma = 1; v.ld = 1; v.exe = 16'h5555;
        v.dest = 1; v.ctrl = 8'h11; v.st = 1; v.e_stall = 1;
        for (int i = 0; i < 3; i++)
            apply(v, $sformatf("stall_hold%0d", i));
        v.st = 0; v.e_valid = 0; v.e_ops = 0; v.e_cnt = 3;
        apply(v, "stall_release");
        v.lma = 2; v.ld = 0; v.mem = 16'h6666;
        v.e_stall = 0; v.e_valid = 1; v.e_ops = 1;
        v.e_opa = 16'h6666; v.e_opb = 16'hDCBA;
        v.e_dest = 1; v.e_ctrl = 8'h11;
        apply(v, "stall_after");

        // reset while in LU_BUBBLE
        v = z; v.vld = 1; v.ua = 1; v.lma = 1; v.ld = 1;
        v.exe = 16'h0101; v.e_stall = 1; v.e_cnt = 4;
        apply(v, "rstb_hz");
        v.rst = 1; v.e_stall = 0; v.e_ops = 1; v.e_cnt = 0;
        apply(v, "rstb_rst");
        v.rst = 0; v.e_stall = 1; v.e_ops = 0; v.e_cnt = 1;
        apply(v, "rstb_run");

        // saturation of the narrow counter
        v = z; v.rst = 1;
        apply(v, "sat_rst");
        for (int i = 1; i <= 9; i++) begin
            v = z; v.vld = 1; v.ub = 1; v.lmb = 1; v.ld = 1;
            v.e_stall = 1; v.e_cnt = i;
            apply(v, $sformatf("sat_hz%0d", i));
            v.lmb = 2; v.ld = 0; v.e_stall = 0; v.e_valid = 1;
            apply(v, $sformatf("sat_cap%0d", i));
        end

        // randomized traffic against the reference model
        v = z; v.rst = 1;
        apply(v, "rnd_rst");
        m_valid = 0; m_bubble = 0; m_cnt = 0;
        m_opa = 0; m_opb = 0; m_dest = 0; m_ctrl = 0;
        for (int n = 0; n < 600; n++) begin
            bit hz;
            bit exp_stall;
            v.rst  = ($urandom_range(0, 63) == 0);
            v.vld  = ($urandom_range(0, 3) != 0);
            v.ua   = $urandom_range(0, 1);
            v.ub   = $urandom_range(0, 1);
            v.ld   = $urandom_range(0, 1);
            v.fl   = ($urandom_range(0, 7) == 0);
            v.st   = ($urandom_range(0, 5) == 0);
            v.lma  = 2'($urandom_range(0, 3));
            v.lmb  = 2'($urandom_range(0, 3));
            v.dest = 3'($urandom);
            v.ctrl = 8'($urandom);
            v.rfa  = 16'($urandom);
            v.rfb  = 16'($urandom);
            v.exe  = 16'($urandom);
            v.mem  = 16'($urandom);
            v.wb   = 16'($urandom);
            drive(v);
            hz = v.vld && v.ld && !m_bubble &&
                 ((v.ua && v.lma == 2'd1) || (v.ub && v.lmb == 2'd1));
            exp_stall = v.st || (!v.fl && hz);
            #1;
            chk($sformatf("rnd%0d stall_id", n),
                32'(stall_id), 32'(exp_stall));
            if (v.rst) begin
                m_valid = 0; m_bubble = 0; m_cnt = 0;
                m_opa = 0; m_opb = 0; m_dest = 0; m_ctrl = 0;
            end else if (v.st) begin
                m_valid = m_valid;
            end else if (v.fl) begin
                m_valid = 0; m_bubble = 0;
            end else if (hz) begin
                m_valid = 0; m_bubble = 1;
                if (m_cnt < 65535) m_cnt++;
            end else begin
                m_valid  = v.vld;
                m_bubble = 0;
                m_opa  = pick(v.lma, v.rfa, v.exe, v.mem, v.wb);
                m_opb  = pick(v.lmb, v.rfb, v.exe, v.mem, v.wb);
                m_dest = v.dest;
                m_ctrl = v.ctrl;
            end
            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d ex_valid", n),
                32'(ex_valid), 32'(m_valid));
            chk($sformatf("rnd%0d stall_count", n),
                32'(stall_count), 32'(m_cnt));
            chk($sformatf("rnd%0d sat count", n),
                32'(s_count), 32'(sat7(m_cnt)));
            if (m_valid) begin
                chk($sformatf("rnd%0d ex_opA", n), 32'(ex_opA), 32'(m_opa));
                chk($sformatf("rnd%0d ex_opB", n), 32'(ex_opB), 32'(m_opb));
                chk($sformatf("rnd%0d ex_dest", n),
                    32'(ex_dest), 32'(m_dest));
                chk($sformatf("rnd%0d ex_ctrl", n),
                    32'(ex_ctrl), 32'(m_ctrl));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
